seg_scan_drv: RTL and testbench
===============================

SEG_SCAN_DRV -- requirements
Module: seg_scan_drv

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clk cycles per digit slot (1 kHz digit rate at 50 MHz).
REQ-002 SHALL have parameter DIGITS, default 4, meaning number of multiplexed digits; only 4 is supported.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge; the block has one clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  display enable; 0 blanks all digits.
REQ-006 SHALL have port num  input  16  four BCD digits; num[3:0] is the rightmost digit (digit 0); the countdown's 8-bit value is zero-extended into it.
REQ-007 SHALL have port dp  input  4  decimal-point/status bits; dp[i] lights on digit i, active-high.
REQ-008 SHALL have port seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.
REQ-009 SHALL have port an  output  4  digit anodes, one-hot active-low; an[i] selects digit i.
REQ-010 SHALL have port frame_tick  output  1  one-cycle pulse at each frame start.

Function
REQ-011 SHALL implement a two-state FSM: IDLE (en=0) and SCAN (en=1); IDLE->SCAN when en=1, SCAN->IDLE when en=0, both evaluated every cycle.
REQ-012 In IDLE, the block SHALL hold an=4'b1111, seg=8'hFF, the divider=0, the digit index=0, and frame_tick=0.
REQ-013 On the IDLE->SCAN cycle, the block SHALL capture num and dp into shadow registers, select digit 0, clear the divider, and pulse frame_tick.
REQ-014 In SCAN, the divider SHALL count 0..SCAN_DIV-1 and wrap; at the terminal count the digit index SHALL advance by 1 modulo 4.
REQ-015 When the digit index wraps from 3 to 0, the block SHALL recapture num and dp into the shadow registers in that same cycle and pulse frame_tick; input changes mid-frame SHALL NOT be displayed until the next frame.
REQ-016 seg and an SHALL be registered and SHALL reflect the new digit index one cycle after the index changes; each digit SHALL be driven for exactly SCAN_DIV cycles.
REQ-017 Decode for values 0-9 SHALL be the standard 7-segment glyphs; 0 -> seg[6:0]=7'b1000000 and 1 -> 7'b1111001.
REQ-018 A non-BCD nibble (A-F) SHALL display '-' (seg[6:0]=7'b0111111).
REQ-019 seg[7] SHALL be ~shadow_dp[index], independent of digit value and of blanking.
REQ-020 Deasserting en mid-frame SHALL blank the outputs on the next cycle; re-enabling SHALL restart at digit 0 per REQ-013.

Reset
REQ-021 When rst=1, the block SHALL force state=IDLE, an=4'b1111, seg=8'hFF, frame_tick=0, divider=0, index=0, shadow num=16'h0000 and shadow dp=4'h0; rst SHALL take priority over en.
REQ-022 Reset asserted mid-scan SHALL take effect on the next clk edge, and no partial digit SHALL persist.

Configuration
REQ-023 Macro SEG_LZ_BLANK_EN, when defined, SHALL enable leading-zero blanking: digit i (i=3..1) SHALL show seg[6:0]=7'b1111111 when its shadow nibble and all higher shadow nibbles are 0; digit 0 SHALL never be blanked.
REQ-024 Without SEG_LZ_BLANK_EN, all four digits SHALL always be decoded, and the blanking logic SHALL be absent.

Structure
REQ-025 Shared package seg_pkg SHALL hold the state enum (IDLE, SCAN), the SEG_BLANK constant (7'b1111111), the SEG_DASH constant (7'b0111111), and the 16-entry glyph table constant.
REQ-026 One sub-module seg_decode SHALL contain the purely combinational nibble-to-7-segment decode (4-bit in, 7-bit out); the FSM, divider, and shadow registers SHALL live in seg_scan_drv.

Verification (SCAN_DIV=4)
REQ-027 Scenario: rst=1 for 2 cycles, then en=1 with num=16'h0099 -> frame_tick on the first en cycle; an=1110 with seg[6:0]=glyph 9 for 4 cycles; then an=1101 with glyph 9.
REQ-028 Scenario: in SCAN, change num from 16'h0099 to 16'h0098 while digit 1 is shown -> digit 0 shows 9 until the next frame_tick, and 8 after it.
REQ-029 Scenario: num=16'h0005 with SEG_LZ_BLANK_EN defined -> digits 3..1 show seg=8'hFF, digit 0 shows glyph 5; without the macro, digits 3..1 show glyph 0 (8'hC0).
REQ-030 Scenario: dp=4'b0101 with num=16'h00A0 -> digit 1 shows dash with seg[7]=1, and digits 0 and 2 have seg[7]=0.
REQ-031 Scenario: drop en during digit 2 -> the next cycle shows an=1111 and seg=8'hFF; re-raise en -> frame_tick fires and digit 0 is shown first.
REQ-032 Scenario: assert rst mid-scan with en=1 -> the next cycle shows all outputs at their reset values, and scan resumes at digit 0 after rst is released.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Entries 0-9 are the standard glyphs; A-F render as a dash.
  localparam logic [6:0] GLYPH_TBL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, SEG_DASH,   SEG_DASH,
    SEG_DASH,   SEG_DASH,   SEG_DASH,   SEG_DASH
  };

endpackage

// File: rtl/seg_decode.sv
// Combinational nibble to active-low 7-segment decode.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = GLYPH_TBL[i_nibble];

endmodule

// File: rtl/seg_scan_drv.sv
// Four-digit multiplexed 7-segment scan driver with frame-synchronous input capture.
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
module seg_scan_drv
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DIGITS   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] num,
  input  logic [3:0]  dp,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [1:0] IDX_LAST = 2'(DIGITS - 1);

  scan_state_e       r_state;
  scan_state_e       w_state_next;
  logic [DIV_W-1:0]  r_div;
  logic [1:0]        r_idx;
  logic [15:0]       r_shadow_num;
  logic [3:0]        r_shadow_dp;
  logic [7:0]        r_seg;
  logic [3:0]        r_an;
  logic              w_div_last;
  logic              w_wrap;
  logic [3:0]        w_nibble;
  logic [6:0]        w_glyph;
  logic [6:0]        w_digit_seg;
  logic [3:0]        w_an;

  assign w_div_last = (r_div == DIV_LAST);
  assign w_wrap     = (r_state == SCAN) && w_div_last && (r_idx == IDX_LAST);
  assign w_nibble   = r_shadow_num[{r_idx, 2'b00} +: 4];
  assign w_an       = ~(4'b0001 << r_idx);

  always_comb begin
    w_state_next = r_state;
    frame_tick   = 1'b0;
    case (r_state)
      IDLE: if (en) w_state_next = SCAN;
      SCAN: if (!en) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    // A frame starts on entry to SCAN and on every index wrap.
    if (!rst && en && ((r_state == IDLE) || w_wrap))
      frame_tick = 1'b1;
  end

  seg_decode u_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_glyph)
  );

`ifdef SEG_LZ_BLANK_EN
  logic w_lz;

  always_comb begin
    w_lz = 1'b0;
    case (r_idx)
      2'd1:    w_lz = (r_shadow_num[15:4]  == 12'h000);
      2'd2:    w_lz = (r_shadow_num[15:8]  == 8'h00);
      2'd3:    w_lz = (r_shadow_num[15:12] == 4'h0);
      default: w_lz = 1'b0;
    endcase
  end

  assign w_digit_seg = w_lz ? SEG_BLANK : w_glyph;
`else
  assign w_digit_seg = w_glyph;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_div        <= '0;
      r_idx        <= 2'd0;
      r_shadow_num <= 16'h0000;
      r_shadow_dp  <= 4'h0;
      r_seg        <= 8'hFF;
      r_an         <= 4'hF;
    end else begin
      r_state <= w_state_next;
      if (!en) begin
        r_div <= '0;
        r_idx <= 2'd0;
        r_seg <= 8'hFF;
        r_an  <= 4'hF;
      end else if (r_state == IDLE) begin
        r_shadow_num <= num;
        r_shadow_dp  <= dp;
        r_div        <= '0;
        r_idx        <= 2'd0;
        r_seg        <= 8'hFF;
        r_an         <= 4'hF;
      end else begin
        // Outputs trail the index by one cycle so each digit holds SCAN_DIV cycles.
        r_an  <= w_an;
        r_seg <= {~r_shadow_dp[r_idx], w_digit_seg};
        if (w_div_last) begin
          r_div <= '0;
          r_idx <= r_idx + 2'd1;
          if (w_wrap) begin
            r_shadow_num <= num;
            r_shadow_dp  <= dp;
          end
        end else begin
          r_div <= r_div + 1'b1;
        end
      end
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule

// File: tb/tb_seg_scan_drv.sv
// Self-checking bench for seg_scan_drv (SCAN_DIV=4): directed sequences, a vector table,
// and randomized traffic checked cycle by cycle against a timing-arithmetic reference model.
module tb_seg_scan_drv;

  localparam int SD    = 4;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [15:0] num = 16'h0000;
  logic [3:0]  dp  = 4'h0;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state
  bit          m_valid = 1'b0;
  bit          m_scan  = 1'b0;
  int          m_s     = 0;
  logic [15:0] m_num   = 16'h0000;
  logic [3:0]  m_dp    = 4'h0;
  logic [7:0]  exp_seg = 8'hFF;
  logic [3:0]  exp_an  = 4'hF;

`ifdef SEG_LZ_BLANK_EN
  localparam logic [7:0] LZ0    = 8'hFF;
  localparam logic [7:0] LZ0_DP = 8'h7F;
`else
  localparam logic [7:0] LZ0    = 8'hC0;
  localparam logic [7:0] LZ0_DP = 8'h40;
`endif

  seg_scan_drv #(.SCAN_DIV(SD), .DIGITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .num        (num),
    .dp         (dp),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic logic [7:0] model_seg(input int d);
    logic [15:0] upper;
    logic [6:0]  g;
    upper = m_num >> (4 * d);
    g = glyph(upper[3:0]);
`ifdef SEG_LZ_BLANK_EN
    if (d > 0 && upper == 16'h0000) g = 7'h7F;
`endif
    return {~m_dp[d], g};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // One clock: compare against the model at negedge, then advance the model at posedge.
  task automatic tick();
    logic exp_ft;
    int   p, d;
    @(negedge clk);
    if (m_valid) begin
      exp_ft = !rst && en && (!m_scan || ((cyc - m_s) % FRAME == 0));
      check("model_seg", {24'b0, seg}, {24'b0, exp_seg});
      check("model_an", {28'b0, an}, {28'b0, exp_an});
      check("model_frame_tick", {31'b0, frame_tick}, {31'b0, exp_ft});
    end
    @(posedge clk);
    if (rst || !en || !m_scan) begin
      exp_seg = 8'hFF;
      exp_an  = 4'hF;
    end else begin
      p = cyc - m_s - 1;
      d = (p / SD) % 4;
      exp_seg = model_seg(d);
      exp_an  = 4'hF ^ (4'b0001 << d);
    end
    if (rst) begin
      m_valid = 1'b1;
      m_scan  = 1'b0;
      m_num   = 16'h0000;
      m_dp    = 4'h0;
    end else if (!en) begin
      m_scan = 1'b0;
    end else if (!m_scan) begin
      m_scan = 1'b1;
      m_s    = cyc;
      m_num  = num;
      m_dp   = dp;
    end else if ((cyc - m_s) % FRAME == 0) begin
      m_num = num;
      m_dp  = dp;
    end
    cyc++;
    #1;
  endtask

  task automatic wait_frame_tick(input string name);
    int budget;
    budget = 0;
    while (frame_tick !== 1'b1 && budget < 3 * FRAME) begin
      tick();
      budget++;
    end
    if (frame_tick !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: frame_tick not seen within %0d cycles", name, 3 * FRAME);
    end
  endtask

  typedef struct {
    logic [15:0] num;
    logic [3:0]  dp;
    int          idx;
    logic [7:0]  seg;
    logic [3:0]  an;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int budget;

    vecs[0]  = '{16'h0099, 4'h0, 0, 8'h90,   4'b1110};
    vecs[1]  = '{16'h0005, 4'h0, 0, 8'h92,   4'b1110};
    vecs[2]  = '{16'h0005, 4'h0, 1, LZ0,     4'b1101};
    vecs[3]  = '{16'h0005, 4'h0, 3, LZ0,     4'b0111};
    vecs[4]  = '{16'h00A0, 4'h5, 1, 8'hBF,   4'b1101};
    vecs[5]  = '{16'h00A0, 4'h5, 0, 8'h40,   4'b1110};
    vecs[6]  = '{16'h00A0, 4'h5, 2, LZ0_DP,  4'b1011};
    vecs[7]  = '{16'h1234, 4'h0, 3, 8'hF9,   4'b0111};
    vecs[8]  = '{16'h1234, 4'h0, 2, 8'hA4,   4'b1011};
    vecs[9]  = '{16'hF00B, 4'h8, 3, 8'h3F,   4'b0111};
    vecs[10] = '{16'hF00B, 4'h8, 1, 8'hC0,   4'b1101};
    vecs[11] = '{16'h0678, 4'h2, 1, 8'h78,   4'b1101};

    // Reset, then first frame of 0099
    rst = 1'b1; en = 1'b0;
    tick(); tick();
    check("reset_seg", {24'b0, seg}, 32'hFF);
    check("reset_an", {28'b0, an}, 32'hF);
    check("reset_frame_tick", {31'b0, frame_tick}, 32'h0);
    rst = 1'b0; en = 1'b1; num = 16'h0099;
    #1;
    check("start_frame_tick", {31'b0, frame_tick}, 32'h1);
    tick();
    check("start_blank_an", {28'b0, an}, 32'hF);
    tick();
    for (int i = 0; i < SD; i++) begin
      check("digit0_an", {28'b0, an}, 32'hE);
      check("digit0_seg", {24'b0, seg}, 32'h90);
      tick();
    end
    check("digit1_an", {28'b0, an}, 32'hD);
    check("digit1_seg", {24'b0, seg}, 32'h90);

    // Mid-frame input change is deferred to the next frame
    num = 16'h0098;
    wait_frame_tick("frame_after_change");
    tick(); tick();
    check("newframe_an", {28'b0, an}, 32'hE);
    check("newframe_seg", {24'b0, seg}, 32'h80);

    // Drop enable during digit 2, then re-enable
    budget = 0;
    while (an !== 4'b1011 && budget < 3 * FRAME) begin
      tick();
      budget++;
    end
    check("reach_digit2_an", {28'b0, an}, 32'hB);
    en = 1'b0;
    tick();
    check("disable_an", {28'b0, an}, 32'hF);
    check("disable_seg", {24'b0, seg}, 32'hFF);
    en = 1'b1;
    #1;
    check("reenable_frame_tick", {31'b0, frame_tick}, 32'h1);
    tick(); tick();
    check("reenable_digit0_an", {28'b0, an}, 32'hE);

    // Reset mid-scan
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("midreset_an", {28'b0, an}, 32'hF);
    check("midreset_seg", {24'b0, seg}, 32'hFF);
    check("midreset_frame_tick", {31'b0, frame_tick}, 32'h0);
    rst = 1'b0;
    #1;
    check("postreset_frame_tick", {31'b0, frame_tick}, 32'h1);
    tick(); tick();
    check("postreset_digit0_an", {28'b0, an}, 32'hE);

    // Vector table: restart a frame, advance to the wanted digit, compare
    for (int v = 0; v < 12; v++) begin
      en = 1'b0;
      tick();
      num = vecs[v].num;
      dp  = vecs[v].dp;
      en  = 1'b1;
      tick(); tick();
      repeat (vecs[v].idx * SD) tick();
      check($sformatf("vec%0d_seg", v), {24'b0, seg}, {24'b0, vecs[v].seg});
      check($sformatf("vec%0d_an", v), {28'b0, an}, {28'b0, vecs[v].an});
    end

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] mask;
      if ($urandom_range(0, 99) < 2) en = ~en;
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 6) == 0) begin
        case ($urandom_range(0, 3))
          0: mask = 16'hFFFF;
          1: mask = 16'h0FFF;
          2: mask = 16'h00FF;
          default: mask = 16'h000F;
        endcase
        num = 16'($urandom) & mask;
      end
      if ($urandom_range(0, 9) == 0) dp = 4'($urandom_range(0, 15));
      tick();
    end
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
